div: RTL and testbench



---
 rtl/div_pkg.sv | 19 +
 rtl/div.sv | 151 +++++++++++++++
 tb/tb_div.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the iterative divider
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// rtl/div.sv - iterative restoring divider, one quotient bit per cycle
module div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e           r_state;
  div_state_e           w_next;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_dvs;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  logic                 w_accept;
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [WIDTH-1:0]     w_op1_abs;
  logic [WIDTH-1:0]     w_op2_abs;
  logic [WIDTH:0]       w_shift;
  logic                 w_q_bit;
  logic [WIDTH-1:0]     w_trial;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic                 w_last;

  assign w_accept  = (start_i == DIV_START) && !annul_i;
  assign w_op1_neg = signed_div_i && opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i && opdata2_i[WIDTH-1];
  // The most negative value maps onto itself, which is the correct magnitude unsigned.
  assign w_op1_abs = w_op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

  // The shifted partial remainder needs one extra bit; when it is not below the divisor
  // the difference always fits back into WIDTH bits.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_q_bit    = (w_shift >= {1'b0, r_dvs});
  assign w_trial    = w_shift[WIDTH-1:0] - r_dvs;
  assign w_rem_next = w_q_bit ? w_trial : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_dvd[WIDTH-2:0], w_q_bit};
  assign w_last     = (r_cnt == DIV_CNT_W'(WIDTH - 1));

  assign w_rem_fix  = r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;
  assign w_quo_fix  = r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;

  assign result_o   = r_result;
  assign ready_o    = r_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DIV_FREE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DIV_FREE: begin
        if (w_accept) begin
          w_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: w_next = DIV_END;
      DIV_ON: begin
        if (annul_i) begin
          w_next = DIV_FREE;
        end else if (w_last) begin
          w_next = DIV_END;
        end
      end
      DIV_END: begin
        if ((start_i == DIV_STOP) || annul_i) begin
          w_next = DIV_FREE;
        end
      end
      default: w_next = DIV_FREE;
    endcase
  end

  // Operand capture, restoring iteration and registered result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
      r_ready  <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          if (w_accept && (opdata2_i != '0)) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_op1_abs;
            r_dvs   <= w_op2_abs;
            r_q_neg <= w_op1_neg ^ w_op2_neg;
            r_r_neg <= w_op1_neg;
          end
        end
        DIV_BY_ZERO: begin
          r_result <= '0;
          r_ready  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i) begin
            r_cnt <= '0;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_result <= {w_rem_fix, w_quo_fix};
              r_ready  <= DIV_RESULT_READY;
            end
          end
        end
        DIV_END: begin
          if ((start_i == DIV_STOP) || annul_i) begin
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - directed self-checking bench for the iterative divider
module tb_div;
  import div_pkg::*;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors;
  int miscompares;
  int lat;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the start edge; counts edges until ready_o is seen high.
  task automatic wait_ready(output int n);
    n = 0;
    #1;
    while (!ready_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int n;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i = ~a;
    opdata2_i = 32'h0;
    wait_ready(n);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, result_o, exp_res);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    check({tag, "_result_clear"}, result_o, 64'd0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;

    #2;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_state", 64'(dut.r_state), 64'(DIV_FREE));
    @(negedge clk);
    rst = 1'b1;

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 32);
    do_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 32);
    do_div("divu_by_zero", 1'b0, 32'h00001234, 32'h0, 64'h0, 1);
    do_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 32);
    do_div("divu_max_16", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 32);

    // Annul mid-divide: sampled at edge N+10.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_state", 64'(dut.r_state), 64'(DIV_FREE));
    check("annul_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("annul_ready_low", 64'(ready_o), 64'd0);
    end

    // Annul while FREE blocks a simultaneous start.
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    check("annul_free_state", 64'(dut.r_state), 64'(DIV_FREE));
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;

    do_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 32);

    // Reset while a result is held in END.
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'hFFFFFFF9;
    opdata2_i    = 32'd2;
    start_i      = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("end_before_reset", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    #2;
    rst = 1'b0;
    #1;
    check("rst_end_result", result_o, 64'd0);
    check("rst_end_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;

    // Reset mid-ON off-edge, then restart with start held high.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd9;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_on_state", 64'(dut.r_state), 64'(DIV_FREE));
    check("rst_on_cnt", 64'(dut.r_cnt), 64'd0);
    check("rst_on_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    wait_ready(lat);
    check("restart_latency", 64'(lat), 64'd32);
    check("restart_result", result_o, {32'h0, 32'h3});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("restart_ready_drop", 64'(ready_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
